// File: rtl/dsp_post_adder.sv
// Post-adder stage of a DSP slice: selectable X/Z operands, carry-in,
// add/subtract, optional pipeline registers and a valid pipeline.
// Ports:
//   clk, rstn          clock; asynchronous active-high reset
//   m, c, dab, pcin    multiplier product, C operand, {D,A,B}, cascade in
//   carryin            external carry-in
//   opmode             [1:0] X sel, [3:2] Z sel, [5] carry-in, [7] subtract
//   ce_*               clock enables for the optional registers
//   in_valid           operands valid this cycle
//   p, pcout           result and cascade copy
//   carryout(f)        carry/borrow out and fabric copy
//   out_valid          p/carryout belong to a valid operand set
module dsp_post_adder #(
  parameter int unsigned CREG        = 1,
  parameter int unsigned OPMODEREG   = 1,
  parameter int unsigned CARRYINREG  = 1,
  parameter int unsigned PREG        = 1,
  parameter int unsigned CARRYOUTREG = 1,
  parameter              CARRYINSEL  = "OPMODE5"
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [35:0] m,
  input  logic [47:0] c,
  input  logic [47:0] dab,
  input  logic [47:0] pcin,
  input  logic        carryin,
  input  logic [7:0]  opmode,
  input  logic        ce_c,
  input  logic        ce_opmode,
  input  logic        ce_carryin,
  input  logic        ce_p,
  input  logic        in_valid,
  output logic [47:0] p,
  output logic [47:0] pcout,
  output logic        carryout,
  output logic        carryoutf,
  output logic        out_valid
);

  localparam int unsigned PW  = 48;
  localparam int unsigned RW  = PW + 1;
  localparam int unsigned OPW = 8;

  localparam bit SEL_OP5 = (CARRYINSEL == "OPMODE5");
  localparam bit SEL_CIN = (CARRYINSEL == "CARRYIN");

  logic [PW-1:0]  c_s;
  logic [OPW-1:0] op_s;
  logic           cin_d;
  logic           cin_s;
  logic           v1_s;
  logic [PW-1:0]  p_fb;
  logic [PW-1:0]  x_mux;
  logic [PW-1:0]  z_mux;
  logic [RW-1:0]  result;

  // Carry-in source; an unrecognised selector forces zero
  assign cin_d = SEL_OP5 ? opmode[5] : (SEL_CIN ? carryin : 1'b0);

  // Stage 1: C, opmode, carry-in and valid registers
  generate
    if (CREG != 0) begin : g_creg
      logic [PW-1:0] c_q;
      always_ff @(posedge clk or posedge rstn) begin
        if (rstn)      c_q <= '0;
        else if (ce_c) c_q <= c;
      end
      assign c_s = c_q;
    end else begin : g_cpass
      assign c_s = c;
    end

    if (OPMODEREG != 0) begin : g_opreg
      logic [OPW-1:0] op_q;
      logic           v1_q;
      always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
          op_q <= '0;
          v1_q <= 1'b0;
        end else if (ce_opmode) begin
          op_q <= opmode;
          v1_q <= in_valid;
        end
      end
      assign op_s = op_q;
      assign v1_s = v1_q;
    end else begin : g_oppass
      assign op_s = opmode;
      assign v1_s = in_valid;
    end

    if (CARRYINREG != 0) begin : g_cinreg
      logic cin_q;
      always_ff @(posedge clk or posedge rstn) begin
        if (rstn)            cin_q <= 1'b0;
        else if (ce_carryin) cin_q <= cin_d;
      end
      assign cin_s = cin_q;
    end else begin : g_cinpass
      assign cin_s = cin_d;
    end
  endgenerate

  // Operand muxes and 49-bit add/subtract
  always_comb begin
    x_mux = '0;
    z_mux = '0;
    case (op_s[1:0])
      2'b00:   x_mux = '0;
      2'b01:   x_mux = PW'(m);
      2'b10:   x_mux = p_fb;
      default: x_mux = dab;
    endcase
    case (op_s[3:2])
      2'b00:   z_mux = '0;
      2'b01:   z_mux = pcin;
      2'b10:   z_mux = p_fb;
      default: z_mux = c_s;
    endcase
    if (op_s[7]) result = {1'b0, z_mux} - ({1'b0, x_mux} + RW'(cin_s));
    else         result = {1'b0, z_mux} + {1'b0, x_mux} + RW'(cin_s);
  end

  // Stage 2: P, carry-out and valid registers share ce_p
  generate
    if (PREG != 0) begin : g_preg
      logic [PW-1:0] p_q;
      logic [PW-1:0] p_d;
      logic          v2_q;
      assign p_d = result[PW-1:0];
      always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
          p_q  <= '0;
          v2_q <= 1'b0;
        end else if (ce_p) begin
          p_q  <= p_d;
          v2_q <= v1_s;
        end
      end
      assign p         = p_q;
      assign p_fb      = p_q;
      assign out_valid = v2_q;
    end else begin : g_ppass
      // Feedback of P without PREG is illegal; tie it off to avoid a loop
      assign p         = result[PW-1:0];
      assign p_fb      = '0;
      assign out_valid = v1_s;
    end

    if (CARRYOUTREG != 0) begin : g_coreg
      logic co_q;
      always_ff @(posedge clk or posedge rstn) begin
        if (rstn)      co_q <= 1'b0;
        else if (ce_p) co_q <= result[PW];
      end
      assign carryout = co_q;
    end else begin : g_copass
      assign carryout = result[PW];
    end
  endgenerate

  assign pcout     = p;
  assign carryoutf = carryout;

  // Inputs that are legitimately unused in some configurations
  logic unused_c;
  assign unused_c = ^{op_s[6], op_s[4], carryin, ce_c, ce_opmode, ce_carryin,
                      ce_p, clk, rstn};

endmodule

// File: tb/tb_dsp_post_adder.sv
// Scoreboard bench for dsp_post_adder: default instance checked by a
// monitor; CARRYIN-select and fully combinational instances checked directly.
module tb_dsp_post_adder;

  logic        clk;
  logic        rstn;
  logic [35:0] m;
  logic [47:0] c, dab, pcin;
  logic        carryin;
  logic [7:0]  opmode;
  logic        ce_c, ce_opmode, ce_carryin, ce_p;
  logic        in_valid;

  logic [47:0] p0, pc0, p1, pc1, p2, pc2;
  logic        co0, cof0, ov0, co1, cof1, ov1, co2, cof2, ov2;

  int checks = 0;
  int errors = 0;
  logic [48:0] exp_q[$];

  dsp_post_adder u0 (
    .clk(clk), .rstn(rstn), .m(m), .c(c), .dab(dab), .pcin(pcin),
    .carryin(carryin), .opmode(opmode), .ce_c(ce_c), .ce_opmode(ce_opmode),
    .ce_carryin(ce_carryin), .ce_p(ce_p), .in_valid(in_valid),
    .p(p0), .pcout(pc0), .carryout(co0), .carryoutf(cof0), .out_valid(ov0)
  );

  dsp_post_adder #(.CARRYINSEL("CARRYIN")) u1 (
    .clk(clk), .rstn(rstn), .m(m), .c(c), .dab(dab), .pcin(pcin),
    .carryin(carryin), .opmode(opmode), .ce_c(ce_c), .ce_opmode(ce_opmode),
    .ce_carryin(ce_carryin), .ce_p(ce_p), .in_valid(in_valid),
    .p(p1), .pcout(pc1), .carryout(co1), .carryoutf(cof1), .out_valid(ov1)
  );

  dsp_post_adder #(.CREG(0), .OPMODEREG(0), .CARRYINREG(0), .PREG(0),
                   .CARRYOUTREG(0)) u2 (
    .clk(clk), .rstn(rstn), .m(m), .c(c), .dab(dab), .pcin(pcin),
    .carryin(carryin), .opmode(opmode), .ce_c(ce_c), .ce_opmode(ce_opmode),
    .ce_carryin(ce_carryin), .ce_p(ce_p), .in_valid(in_valid),
    .p(p2), .pcout(pc2), .carryout(co2), .carryoutf(cof2), .out_valid(ov2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [48:0] act,
                     input logic [48:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: every valid output of u0 must match the next queued value
  always @(negedge clk) begin
    if (ov0 === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected act=%h exp=none", {co0, p0});
      end else begin
        chk("sb_result", {co0, p0}, exp_q.pop_front());
      end
      chk("sb_pcout", 49'(pc0), 49'(p0));
      chk("sb_carryoutf", 49'(cof0), 49'(co0));
    end
  end

  // Apply one operand set, keep it stable through the P capture edge
  task automatic issue(input logic [7:0] op, input logic [35:0] mm,
                       input logic [47:0] cc, input logic [47:0] dd,
                       input logic [47:0] pc, input logic cin,
                       input logic [48:0] exp);
    opmode = op; m = mm; c = cc; dab = dd; pcin = pc; carryin = cin;
    exp_q.push_back(exp);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; m = '0; c = '0; dab = '0; pcin = '0; carryin = 1'b0;
    opmode = '0; ce_c = 1'b1; ce_opmode = 1'b1; ce_carryin = 1'b1;
    ce_p = 1'b1; in_valid = 1'b0;
    #1 rstn = 1'b1;
    #2;
    chk("rst_p", 49'(p0), 49'd0);
    chk("rst_pcout", 49'(pc0), 49'd0);
    chk("rst_co", {47'd0, co0, cof0}, 49'd0);
    chk("rst_valid", 49'(ov0), 49'd0);
    @(posedge clk); #1 rstn = 1'b0;

    // Basic add with latency check
    opmode = 8'h0D; m = 36'd1000; c = 48'd24; in_valid = 1'b1;
    exp_q.push_back({1'b0, 48'd1024});
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("lat_early_valid", 49'(ov0), 49'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_valid", 49'(ov0), 49'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_single_valid", 49'(ov0), 49'd0);

    // Reset to P=0 then accumulate m=5 over four valid cycles
    #2 rstn = 1'b1;
    #1 chk("rst2_p", 49'(p0), 49'd0);
    @(posedge clk); #1 rstn = 1'b0;
    opmode = 8'h09; m = 36'd5; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) exp_q.push_back(49'(5 * i));
    repeat (4) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    @(posedge clk); #1 m = '0;
    @(posedge clk); #1 ce_p = 1'b0; m = 36'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("hold_p", 49'(p0), 49'd20);
    chk("hold_valid", 49'(ov0), 49'd0);

    // Asynchronous reset between edges while p=20
    #2 rstn = 1'b1;
    #1;
    chk("async_p", 49'(p0), 49'd0);
    chk("async_co", 49'(co0), 49'd0);
    chk("async_valid", 49'(ov0), 49'd0);
    @(posedge clk); #1 rstn = 1'b0; ce_p = 1'b1;
    issue(8'h09, 36'd5, 48'd0, 48'd0, 48'd0, 1'b0, 49'd5);

    // Directed vectors {carryout, p}
    issue(8'h8D, 36'd11, 48'd10, 48'd0, 48'd0, 1'b0, {1'b1, 48'hFFFF_FFFF_FFFF});
    issue(8'hAD, 36'd30, 48'd100, 48'd0, 48'd0, 1'b0, 49'd69);
    issue(8'h2D, 36'd1000, 48'd24, 48'd0, 48'd0, 1'b0, 49'd1025);
    issue(8'h0A, 36'd1000, 48'd24, 48'd0, 48'd0, 1'b0, 49'd2050);
    issue(8'h8A, 36'd1000, 48'd24, 48'd0, 48'd0, 1'b0, 49'd0);
    issue(8'h07, 36'd0, 48'd0, 48'h1234_5678_9ABC, 48'd1, 1'b0,
          49'h1234_5678_9ABD);
    issue(8'h0C, 36'd0, 48'hFFFF_FFFF_FFFF, 48'd0, 48'd0, 1'b1,
          {1'b0, 48'hFFFF_FFFF_FFFF});
    chk("cin_port_p", 49'(p1), 49'd0);
    chk("cin_port_pcout", 49'(pc1), 49'd0);
    chk("cin_port_co", {47'd0, co1, cof1}, 49'd3);
    carryin = 1'b0;
    issue(8'h0D, 36'd1, 48'hFFFF_FFFF_FFFF, 48'd0, 48'd0, 1'b0, {1'b1, 48'd0});
    issue(8'h50, 36'd9, 48'd9, 48'd9, 48'd9, 1'b0, 49'd0);

    // Fully combinational instance, held in reset to show rstn has no effect
    @(negedge clk);
    rstn = 1'b1;
    opmode = 8'h01; m = 36'd7; in_valid = 1'b1;
    #1;
    chk("comb_p", 49'(p2), 49'd7);
    chk("comb_pcout", 49'(pc2), 49'd7);
    chk("comb_valid", 49'(ov2), 49'd1);
    m = 36'hF_FFFF_FFFF; in_valid = 1'b0;
    #1;
    chk("comb_p_max", 49'(p2), 49'h0000_000F_FFFF_FFFF);
    chk("comb_valid_low", 49'(ov2), 49'd0);
    opmode = 8'h8D; m = 36'd11; c = 48'd10;
    #1;
    chk("comb_sub", {co2, p2}, {1'b1, 48'hFFFF_FFFF_FFFF});
    chk("comb_cof", 49'(cof2), 49'd1);
    chk("reset_valid_u0", 49'(ov0), 49'd0);

    @(posedge clk); #1;
    chk("sb_drained", 49'(exp_q.size()), 49'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_post_adder.md
DSP_POST_ADDER -- requirements
Module: dsp_post_adder

Interface
REQ-001 Parameter CREG, default 1: 1 = register C input (ce_c), 0 = pass through.
REQ-002 Parameter OPMODEREG, default 1: 1 = register opmode (ce_opmode), 0 = pass through.
REQ-003 Parameter CARRYINREG, default 1: 1 = register selected carry-in (ce_carryin), 0 = pass through.
REQ-004 Parameter PREG, default 1: 1 = register post-adder result (ce_p), 0 = pass through.
REQ-005 Parameter CARRYOUTREG, default 1: 1 = register carry-out (ce_p), 0 = pass through.
REQ-006 Parameter CARRYINSEL, default "OPMODE5": "OPMODE5" = carry-in from opmode[5]; "CARRYIN" = carry-in from carryin port.
REQ-007 clk  input  1  clock; all registers capture on rising edge.
REQ-008 rstn  input  1  reset, asynchronous, active-high; clears every register.
REQ-009 m  input  36  product from multiplier-stage register.
REQ-010 c  input  48  C operand.
REQ-011 dab  input  48  concatenated {D[11:0],A[17:0],B[17:0]} from the input-stage registers.
REQ-012 pcin  input  48  cascade input from the previous slice.
REQ-013 carryin  input  1  external carry-in.
REQ-014 opmode  input  8  bits [1:0] X select, [3:2] Z select, [5] carry-in, [7] add/sub; bits 4 and 6 ignored.
REQ-015 ce_c, ce_opmode, ce_carryin, ce_p  input  1 each  clock enables for their registers.
REQ-016 in_valid  input  1  operands on this cycle are valid.
REQ-017 p  output  48  post-adder result.
REQ-018 pcout  output  48  copy of p for cascade.
REQ-019 carryout, carryoutf  output  1 each  carry-out and its fabric copy (identical).
REQ-020 out_valid  output  1  p/carryout correspond to a valid operand set.

Function
REQ-021 Each optional register SHALL load its input when its enable is 1, hold when 0; reset overrides enable.
REQ-022 X mux (opmode[1:0]) SHALL select: 00 zero; 01 {12'b0,m}; 10 p (registered P); 11 dab.
REQ-023 Z mux (opmode[3:2]) SHALL select: 00 zero; 01 pcin; 10 p (registered P); 11 c (after CREG).
REQ-024 CIN SHALL be opmode[5] or carryin per CARRYINSEL, delayed by CARRYINREG; any other CARRYINSEL value SHALL force CIN = 0.
REQ-025 opmode[7]=0: 49-bit sum = {0,Z} + {0,X} + CIN; opmode[7]=1: 49-bit result = {0,Z} - ({0,X} + CIN).
REQ-026 p SHALL be result[47:0] (wraps modulo 2^48); carryout SHALL be result[48] (borrow flag on subtract).
REQ-027 Selecting p in X or Z with PREG=0 is illegal; behaviour undefined, not verified.
REQ-028 Selecting p in both X and Z SHALL be legal (PREG=1): next P = 2*P (+/- as opmode[7] dictates).
REQ-029 Latency in_valid->out_valid SHALL be OPMODEREG + PREG cycles: valid stage 1 follows ce_opmode, stage 2 follows ce_p; stages bypassed when parameter is 0.
REQ-030 With all defaults, operands at edge N appear on p at edge N+2; X/Z = p uses the P value present at the adder input cycle.
REQ-031 pcout SHALL equal p every cycle; carryoutf SHALL equal carryout every cycle.
REQ-032 ce_p=0 SHALL freeze p, carryout and out_valid stage 2 simultaneously.

Reset
REQ-033 rstn=1 SHALL immediately (no clock) drive all registers to 0: p=0, pcout=0, carryout=0, carryoutf=0, out_valid=0.
REQ-034 Reset mid-accumulation SHALL discard the accumulated value; first edge after release resumes from P=0.
REQ-035 With every register parameter 0, outputs SHALL be purely combinational and unaffected by rstn except out_valid=in_valid.

Verification
REQ-036 Defaults, opmode=8'b0000_1101 (X=m, Z=c), m=36'd1000, c=48'd24, valid for one cycle -> p=1024, carryout=0, out_valid=1 exactly 2 cycles later.
REQ-037 Accumulate: opmode X=m, Z=p, m=5 held 4 cycles from P=0 -> p steps 5,10,15,20; then ce_p=0 -> p holds 20.
REQ-038 Subtract: opmode[7]=1, Z=c=10, X=m=11, CIN=0 -> p=48'hFFFF_FFFF_FFFF, carryout=1.
REQ-039 Carry: Z=c=48'hFFFF_FFFF_FFFF, X=0, CARRYINSEL="CARRYIN", carryin=1 -> p=0, carryout=1, carryoutf=1.
REQ-040 Async reset: assert rstn between clock edges while p=20 -> p, carryout, out_valid go 0 before next edge; after release accumulate of m=5 gives p=5.
REQ-041 All register parameters 0: change m with X=m, Z=0 -> p follows m in same cycle, out_valid=in_valid.
